// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg -- shared constants, types and helpers for the sync_fifo block.
//   MIN_DEPTH / MAX_DEPTH : legal range of the DEPTH parameter (powers of two)
//   ptr_width()           : pointer width for a given depth (one extra wrap bit)
//   occupancy_t           : occupancy value wide enough for the largest legal FIFO
package sync_fifo_pkg;

  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 256;

  // The extra MSB lets equal low bits mean either "empty" or "full".
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [$clog2(MAX_DEPTH):0] occupancy_t;

endpackage

// File: rtl/dti.sv
// dti -- valid/ready data stream interface.
//   data  : payload, W bits
//   valid : producer has a word on data
//   ready : consumer accepts the word this cycle
// A transfer happens on a clock edge where valid && ready.
interface dti #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram -- DEPTH x WIDTH storage for sync_fifo.
//   clk     : write clock
//   i_we    : write enable, sampled on rising clk
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address (asynchronous read)
//   o_rdata : read data, combinational from i_raddr
// Contents are deliberately not reset.
module sync_fifo_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo -- synchronous valid/ready FIFO, DEPTH entries, no fall-through.
//   clk   : clock, all state on rising edge
//   rst   : synchronous active-high reset (clears pointers, not storage)
//   din   : upstream stream (dti consumer); din.ready = !full
//   dout  : downstream stream (dti producer); dout.valid = !empty
//   level : occupancy, only when SYNC_FIFO_LEVEL_EN is defined
// Optional feature macro: SYNC_FIFO_LEVEL_EN adds the registered level counter.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  dti.consumer                            din,
  dti.producer                            dout
`ifdef SYNC_FIFO_LEVEL_EN
  ,
  output logic [ptr_width(DEPTH)-1:0]     level
`endif
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam int W     = $bits(din.data);
  localparam int W_OUT = $bits(dout.data);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_INC  = PTR_W'(1);

  if ((DEPTH < MIN_DEPTH) || (DEPTH > MAX_DEPTH) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo: DEPTH %0d is not a power of two in [%0d, %0d]", DEPTH, MIN_DEPTH, MAX_DEPTH);
  end
  if (W != W_OUT) begin : g_bad_width
    $error("sync_fifo: din width %0d differs from dout width %0d", W, W_OUT);
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [W-1:0]     w_rdata;

  // Same address with opposite wrap bits means the writer lapped the reader.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Handshakes depend only on registered pointers; a read while full does not
  // open the write side until the next cycle.
  assign w_wr_en    = din.valid && !w_full;
  assign w_rd_en    = !w_empty && dout.ready;
  assign din.ready  = !w_full;
  assign dout.valid = !w_empty;
  assign dout.data  = w_rdata;

  // Pointer registers, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_INC;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_INC;
      end
    end
  end

  sync_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (din.data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

`ifdef SYNC_FIFO_LEVEL_EN
  logic [PTR_W-1:0] r_level;

  // Occupancy counter tracking wr_ptr - rd_ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= PTR_ZERO;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + PTR_INC;
        2'b01:   r_level <= r_level - PTR_INC;
        default: r_level <= r_level;
      endcase
    end
  end

  assign level = r_level;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo -- scoreboard bench for sync_fifo (DEPTH=4, 8-bit data).
// Stimulus pushes each accepted word into exp_q; the negedge monitor pops and
// compares on every dout transfer and checks dout stability while stalled.
module tb_sync_fifo;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   n_out;
  logic ready_cmd;
  logic rand_ready_en;
  logic prev_hold;
  logic [7:0] prev_data;
  logic [7:0] exp_q [$];

  dti #(.W(8)) din_if ();
  dti #(.W(8)) dout_if ();

`ifdef SYNC_FIFO_LEVEL_EN
  logic [2:0] level;
`endif

  sync_fifo #(.DEPTH(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din_if),
    .dout (dout_if)
`ifdef SYNC_FIFO_LEVEL_EN
    ,
    .level(level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Single driver of dout.ready: either the commanded value or a coin flip.
  always @(posedge clk) begin
    #2;
    if (rand_ready_en) dout_if.ready = 1'($urandom_range(0, 1));
    else               dout_if.ready = ready_cmd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare outputs against the scoreboard, check stall stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(dout_if.valid), 32'd1);
        check("hold_data", 32'(dout_if.data), 32'(prev_data));
      end
      if (dout_if.valid && dout_if.ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output", dout_if.data);
        end else begin
          check("out_data", 32'(dout_if.data), 32'(exp_q.pop_front()));
          n_out++;
        end
      end
      prev_hold = dout_if.valid && !dout_if.ready;
      prev_data = dout_if.data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word until accepted (bounded); record it as expected output.
  task automatic send(input logic [7:0] d);
    din_if.valid = 1'b1;
    din_if.data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (din_if.ready) begin
        exp_q.push_back(d);
        tick();
        din_if.valid = 1'b0;
        return;
      end
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance", d);
    din_if.valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c0;
    int n0;
    n_cmp = 0; n_err = 0; n_out = 0; cyc = 0;
    prev_hold = 1'b0; prev_data = 8'h00;
    ready_cmd = 1'b0; rand_ready_en = 1'b0;
    rst = 1'b1;
    din_if.valid = 1'b0;
    din_if.data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle.
    @(negedge clk);
    check("rst_dout_valid", 32'(dout_if.valid), 32'd0);
    check("rst_din_ready", 32'(din_if.ready), 32'd1);
`ifdef SYNC_FIFO_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
`endif

    // Fill to full with the reader stalled.
    tick();
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    @(negedge clk);
    check("full_din_ready", 32'(din_if.ready), 32'd0);
    check("full_dout_valid", 32'(dout_if.valid), 32'd1);
    check("full_head", 32'(dout_if.data), 32'hA1);
`ifdef SYNC_FIFO_LEVEL_EN
    check("full_level", 32'(level), 32'd4);
`endif
    tick();
    din_if.valid = 1'b1;
    din_if.data  = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("a5_refused", 32'(din_if.ready), 32'd0);
      tick();
    end

    // Drain from full; the write offered during the first read is refused.
    ready_cmd = 1'b1;
    tick();
    din_if.valid = 1'b0;
    @(negedge clk);
    check("ready_after_read", 32'(din_if.ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("drained_valid", 32'(dout_if.valid), 32'd0);
    check("drained_q", 32'(exp_q.size()), 32'd0);

    // Streaming 0..19 across pointer wrap at one word per cycle.
    tick();
    c0 = cyc;
    n0 = n_out;
    for (int i = 0; i < 20; i++) send(8'(i));
    tick();
    check("stream_cycles", 32'(cyc - c0), 32'd21);
    check("stream_count", 32'(n_out - n0), 32'd20);

    // Random valid/ready for 1000 words.
    rand_ready_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) tick();
      send(8'($urandom_range(0, 255)));
    end
    rand_ready_en = 1'b0;
    ready_cmd = 1'b1;
    wait_drain();

    // Reset with entries stored: they must never appear.
    ready_cmd = 1'b0;
    tick(); tick();
    send(8'h11); send(8'h22); send(8'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(dout_if.valid), 32'd0);
    check("mid_rst_ready", 32'(din_if.ready), 32'd1);
    ready_cmd = 1'b1;
    tick();
    n0 = n_out;
    send(8'h55);
    wait_drain();
    check("post_rst_count", 32'(n_out - n0), 32'd1);
    tick(); tick();
    check("total_out", 32'(n_out), 32'd1025);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of storage entries; legal values are powers of two from 2 to 256.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port din, dti.consumer, width $size(din.data): the upstream stream (data, valid, ready).
REQ-005 The block SHALL have port dout, dti.producer, width $size(dout.data): the downstream stream (data, valid, ready).
REQ-006 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy; present only when SYNC_FIFO_LEVEL_EN is defined.

Function
REQ-007 The block SHALL define a write as din.valid && din.ready and a read as dout.valid && dout.ready, both sampled at the rising clk edge.
REQ-008 The block SHALL keep read and write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
REQ-009 The block SHALL flag empty when the pointers are equal, and full when the low bits are equal and the MSBs differ.
REQ-010 The block SHALL drive din.ready = !full, with no combinational dependency on dout.ready or din.valid.
REQ-011 The block SHALL drive dout.valid = !empty and dout.data = mem[rd_ptr low bits], with no combinational path from din.
REQ-012 The block SHALL have a write-to-output latency of exactly 1 cycle: data written at edge N is visible on dout from edge N until the edge after it is read.
REQ-013 The block SHALL hold dout.data and dout.valid stable while dout.valid && !dout.ready.
REQ-014 On a simultaneous read and write, the block SHALL advance both pointers and leave the occupancy unchanged.
REQ-015 When full, the block SHALL refuse writes even if a read occurs in the same cycle; din.ready rises in the cycle after the read.
REQ-016 When empty, the block SHALL not present written data in the same cycle (no fall-through).
REQ-017 Pointers SHALL wrap modulo 2*DEPTH, and data order SHALL be strictly FIFO across wrap.
REQ-018 Throughput SHALL be one transfer per cycle in steady state when neither full nor empty.
REQ-019 The block SHALL not check upstream protocol; din.data is captured only on a write.
REQ-020 A $error SHALL fire at elaboration if $size(din.data) != $size(dout.data) or DEPTH is not a legal power of two.

Reset
REQ-021 While rst is high, both pointers SHALL clear to 0, giving dout.valid=0, din.ready=1 and level=0 on the cycle after rst is sampled.
REQ-022 A reset asserted mid-operation SHALL discard all stored entries, and no stale data SHALL appear after reset.
REQ-023 Storage contents SHALL not be reset.

Configuration
REQ-024 With macro SYNC_FIFO_LEVEL_EN defined, the block SHALL add the level output as a registered counter (wr_ptr - rd_ptr), updated each edge (+1 write only, -1 read only, unchanged on both or neither).
REQ-025 Without SYNC_FIFO_LEVEL_EN, the block SHALL omit the level port and counter, and all other behaviour SHALL be identical.

Structure
REQ-026 Package sync_fifo_pkg SHALL hold the pointer-width function (clog2(DEPTH)+1), the MIN_DEPTH=2 and MAX_DEPTH=256 constants, and the occupancy typedef.
REQ-027 Storage SHALL be a single sub-module, sync_fifo_ram: DEPTH x width, one synchronous write port and one asynchronous read port.

Verification
REQ-028 Reset then idle -> dout.valid=0, din.ready=1, level=0.
REQ-029 DEPTH=4, write 0xA1..0xA4 with dout.ready=0 -> din.ready=0 after the 4th write, level=4; a 5th valid word 0xA5 is not accepted.
REQ-030 From full, hold dout.ready=1 for 4 cycles -> outputs 0xA1,0xA2,0xA3,0xA4 in order; din.ready=1 the cycle after the first read.
REQ-031 Continuous din.valid and dout.ready for 20 words 0..19 -> 20 outputs in order at 1 per cycle after 1-cycle latency; pointer wrap crossed; level stays 1.
REQ-032 Random valid/ready at 50% for 1000 words -> output equals input sequence; dout stable whenever valid && !ready.
REQ-033 3 entries stored, rst pulsed 1 cycle -> dout.valid=0 next cycle; the next written word 0x55 is the first output.
